div_mnbit_seq: RTL and testbench

- Sequential unsigned integer divider; the inverse operation of the single-cycle multiplier mult_mnbit_1cc.
- Divides the N-bit g_input (dividend) by the M-bit e_input (divisor) with restoring division, producing one quotient bit per cycle.
- Sits beside the multiplier in the arithmetic benchmark set. Benches close the loop: q*e_input + r == g_input.
- Start/busy/done handshake, so it can be chained behind other sequential benchmark blocks.

---
 rtl/div_mnbit_seq_pkg.sv | 11 +
 rtl/div_mnbit_seq_step.sv | 20 ++
 rtl/div_mnbit_seq.sv | 121 ++++++++++++
 tb/tb_div_mnbit_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/div_mnbit_seq_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  // Width of the step counter that holds N-1 down to 0.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_mnbit_seq_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int M = 8
) (
  input  logic [M-1:0] rem,
  input  logic         in_bit,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] rem_next,
  output logic         qbit
);

  logic [M:0] t;

  assign t    = {rem, in_bit};
  assign qbit = (t >= {1'b0, divisor});
  // When the subtract happens the true difference is below the divisor, so
  // the low M bits carry the whole result.
  assign rem_next = qbit ? (t[M-1:0] - divisor) : t[M-1:0];

endmodule

// File: rtl/div_mnbit_seq.sv
// Sequential unsigned N/M-bit restoring divider, one quotient bit per cycle,
// with start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one quotient bit per cycle, cnt counts N-1 down to 0
//       | (divide-by-zero spends a single RUN cycle, then forces the result)
// DONE  | done pulse; q/r already loaded; start ignored
module div_mnbit_seq
  import div_pkg::*;
#(
  parameter int N = 8,
  parameter int M = N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] g_input,
  input  logic [M-1:0] e_input,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [M-1:0] r
);

  localparam int CNT_W = cnt_width(N);

  div_state_t       state_q, state_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [M-1:0]     dvs_q, dvs_d;
  logic [M-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     q_q, q_d;
  logic [M-1:0]     r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [M-1:0]     rem_next;
  logic             qbit;

  div_step #(.M(M)) u_step (
    .rem      (rem_q),
    .in_bit   (dvd_q[N-1]),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = g_input;
          dvs_d   = e_input;
          rem_d   = '0;
          cnt_d   = (e_input == '0) ? '0 : CNT_W'(N - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        dvd_d = {dvd_q[N-2:0], qbit};
        rem_d = rem_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          if (dvs_q == '0) begin
            // dvd_q still holds the untouched dividend on this single step
            q_d = '1;
            r_d = M'(dvd_q);
          end else begin
            q_d = {dvd_q[N-2:0], qbit};
            r_d = rem_next;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;

endmodule

// File: tb/tb_div_mnbit_seq.sv
// Scoreboard bench for div_mnbit_seq (N=M=8): directed vectors, monitor on done.
module tb_div_mnbit_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] g_in;
  logic [7:0] e_in;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [7:0] r;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] g;
    logic [7:0] e;
    logic [7:0] q;
    logic [7:0] r;
  } exp_t;

  exp_t sb[$];

  div_mnbit_seq #(.N(8), .M(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .g_input (g_in),
    .e_input (e_in),
    .busy    (busy),
    .done    (done),
    .q       (q),
    .r       (r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got q=%0h r=%0h want no done", q, r);
      end else begin
        exp_t ex;
        ex = sb.pop_front();
        chk("q", 32'(q), 32'(ex.q));
        chk("r", 32'(r), 32'(ex.r));
        if (ex.e != 8'h00) begin
          chk("q*e+r==g", 32'(q) * 32'(ex.e) + 32'(r), 32'(ex.g));
          chk("r<e", 32'(r < ex.e), 32'd1);
        end else begin
          chk("div0_r==g", 32'(r), 32'(ex.g));
        end
      end
    end
  end

  task automatic issue(input logic [7:0] g, input logic [7:0] e,
                       input logic [7:0] eq, input logic [7:0] er);
    exp_t ex;
    @(posedge clk); #1;
    start = 1'b1;
    g_in  = g;
    e_in  = e;
    ex.g = g; ex.e = e; ex.q = eq; ex.r = er;
    sb.push_back(ex);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called one sample after the accepting edge; counts edges until done.
  task automatic wait_done(input string nm, input int lat);
    int n = 0;
    int nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    if (busy) nb++;
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_busy_cycles"}, 32'(nb), 32'(lat + 1));
  endtask

  task automatic run_op(input string nm, input logic [7:0] g, input logic [7:0] e,
                        input logic [7:0] eq, input logic [7:0] er, input int lat);
    issue(g, e, eq, er);
    wait_done(nm, lat);
    @(posedge clk); #1;
    chk({nm, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    g_in  = 8'h00;
    e_in  = 8'h00;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_r", 32'(r), 32'd0);
    rst = 1'b1;

    run_op("ff_47", 8'hFF, 8'h47, 8'h03, 8'h2A, 8);
    run_op("42_47", 8'h42, 8'h47, 8'h00, 8'h42, 8);
    run_op("64_13", 8'h64, 8'h13, 8'h05, 8'h05, 8);
    run_op("div0", 8'h47, 8'h00, 8'hFF, 8'h47, 1);
    run_op("ff_01", 8'hFF, 8'h01, 8'hFF, 8'h00, 8);
    run_op("00_ff", 8'h00, 8'hFF, 8'h00, 8'h00, 8);

    // start and operand changes mid-run and during DONE must be ignored
    issue(8'h64, 8'h13, 8'h05, 8'h05);
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1;
    g_in  = 8'h10;
    e_in  = 8'h02;
    wait_done("midrun", 6);
    @(posedge clk); #1;
    start = 1'b0;
    chk("held_start_busy", 32'(busy), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("held_start_idle", {30'd0, busy, done}, 32'd0);
    end

    // asynchronous reset in RUN cycle 4 aborts with no done pulse
    @(posedge clk); #1;
    start = 1'b1;
    g_in  = 8'h64;
    e_in  = 8'h13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_abort_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_r", 32'(r), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_op("47_47", 8'h47, 8'h47, 8'h01, 8'h00, 8);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
